// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: stall bit positions, nested
// stall vectors, sequencer states and the zero word.
package pipe_ctrl_pkg;

    localparam int STALL_PC     = 0;
    localparam int STALL_IF_ID  = 1;
    localparam int STALL_ID_EX  = 2;
    localparam int STALL_EX_MEM = 3;
    localparam int STALL_MEM_WB = 4;
    localparam int STALL_WB     = 5;

    // Each requester holds its own stage and everything upstream of it.
    localparam logic [5:0] STALL_VEC_MEM  = 6'b011111;
    localparam logic [5:0] STALL_VEC_EX   = 6'b001111;
    localparam logic [5:0] STALL_VEC_ID   = 6'b000111;
    localparam logic [5:0] STALL_VEC_IF   = 6'b000011;
    localparam logic [5:0] STALL_VEC_NONE = 6'b000000;

    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    typedef enum logic {
        RUN        = 1'b0,
        FLUSH_PEND = 1'b1
    } pipe_state_t;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Saturating stall-cycle and flush counters for pipe_ctrl.
// Only instantiated when PIPE_PERF_CNT_EN is defined.
module pipe_perf_cnt
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_inc,
    input  logic             flush_inc,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (stall_inc && (stall_cycles != '1))
                stall_cycles <= stall_cycles + 1'b1;
            if (flush_inc && (flush_count != '1))
                flush_count <= flush_count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stall merge, exception flush (deferred across MEM stalls)
// and stall watchdog. Define PIPE_PERF_CNT_EN to add the perf counter ports.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int STALL_TIMEOUT = 1024,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_if,
    input  logic             stallreq_id,
    input  logic             stallreq_ex,
    input  logic             stallreq_mem,
    input  logic             excp_req,
    input  logic [31:0]      excp_pc,
    output logic [5:0]       stall,
    output logic             flush,
    output logic [31:0]      new_pc,
    output logic             stall_timeout
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
`endif
);

    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(STALL_TIMEOUT - 1);

    pipe_state_t      state, state_next;
    logic [31:0]      pend_pc, pend_pc_next;
    logic [CNT_W-1:0] wdog;
    logic             timeout_q;
    logic [5:0]       stall_c;
    logic             flush_c;
    logic [31:0]      new_pc_c;

    always_comb begin
        state_next   = state;
        pend_pc_next = pend_pc;
        flush_c      = 1'b0;
        new_pc_c     = ZeroWord;

        if (stallreq_mem)     stall_c = STALL_VEC_MEM;
        else if (stallreq_ex) stall_c = STALL_VEC_EX;
        else if (stallreq_id) stall_c = STALL_VEC_ID;
        else if (stallreq_if) stall_c = STALL_VEC_IF;
        else                  stall_c = STALL_VEC_NONE;

        case (state)
            RUN: begin
                if (excp_req) begin
                    if (stallreq_mem) begin
                        // Bus transfer in flight: hold and flush once it completes.
                        pend_pc_next = excp_pc;
                        state_next   = FLUSH_PEND;
                    end else begin
                        flush_c  = 1'b1;
                        new_pc_c = excp_pc;
                        stall_c  = STALL_VEC_NONE;
                    end
                end
            end
            FLUSH_PEND: begin
                // Later exceptions are ignored; the latched one is older.
                if (!stallreq_mem) begin
                    flush_c    = 1'b1;
                    new_pc_c   = pend_pc;
                    stall_c    = STALL_VEC_NONE;
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            pend_pc   <= ZeroWord;
            wdog      <= '0;
            timeout_q <= 1'b0;
        end else begin
            state   <= state_next;
            pend_pc <= pend_pc_next;
            if ((stall_c != STALL_VEC_NONE) && !flush_c) begin
                if (wdog != '1)
                    wdog <= wdog + 1'b1;
            end else begin
                wdog <= '0;
            end
            if ((stall_c != STALL_VEC_NONE) && (wdog == WDOG_LAST))
                timeout_q <= 1'b1;
        end
    end

    assign stall         = rst ? STALL_VEC_NONE : stall_c;
    assign flush         = rst ? 1'b0 : flush_c;
    assign new_pc        = rst ? ZeroWord : new_pc_c;
    assign stall_timeout = rst ? 1'b0 : timeout_q;

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles_q, flush_count_q;

    pipe_perf_cnt #(.CNT_W(CNT_W)) u_perf (
        .clk          (clk),
        .rst          (rst),
        .stall_inc    (stall != STALL_VEC_NONE),
        .flush_inc    (flush),
        .stall_cycles (stall_cycles_q),
        .flush_count  (flush_count_q)
    );

    assign stall_cycles = rst ? '0 : stall_cycles_q;
    assign flush_count  = rst ? '0 : flush_count_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed test-plan scenarios followed by
// random traffic, all scored against a transaction-level model.
module tb_pipe_ctrl;

    localparam int TO    = 4;
    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             stallreq_if = 0, stallreq_id = 0, stallreq_ex = 0, stallreq_mem = 0;
    logic             excp_req = 0;
    logic [31:0]      excp_pc = 0;
    logic [5:0]       stall;
    logic             flush;
    logic [31:0]      new_pc;
    logic             stall_timeout;
`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles, flush_count;
`endif

    pipe_ctrl #(.STALL_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .stallreq_if   (stallreq_if),
        .stallreq_id   (stallreq_id),
        .stallreq_ex   (stallreq_ex),
        .stallreq_mem  (stallreq_mem),
        .excp_req      (excp_req),
        .excp_pc       (excp_pc),
        .stall         (stall),
        .flush         (flush),
        .new_pc        (new_pc),
        .stall_timeout (stall_timeout)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stall_cycles  (stall_cycles),
        .flush_count   (flush_count)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;

    // Model: an exception waiting on the bus, the current run of stalled
    // cycles, the sticky timeout, and event totals.
    bit          m_pending = 0;
    logic [31:0] m_pend_pc = 0;
    int          m_run = 0;
    bit          m_to = 0;
    int          m_sc = 0, m_fc = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // One clock: drive inputs after negedge, check outputs, advance the model
    // past the following posedge.
    task automatic cycle(input bit r, input bit i_f, input bit i_d, input bit e_x,
                         input bit m_em, input bit e_rq, input logic [31:0] epc);
        logic [5:0]  st_e;
        bit          fl_e;
        logic [31:0] pc_e;
        @(negedge clk);
        rst = r; stallreq_if = i_f; stallreq_id = i_d; stallreq_ex = e_x;
        stallreq_mem = m_em; excp_req = e_rq; excp_pc = epc;
        #1;
        fl_e = 0; pc_e = 0;
        st_e = m_em ? 6'b011111 : e_x ? 6'b001111 : i_d ? 6'b000111 : i_f ? 6'b000011 : 6'b0;
        if (!m_em && (m_pending || e_rq)) begin
            fl_e = 1;
            pc_e = m_pending ? m_pend_pc : epc;
            st_e = 0;
        end
        if (r) begin st_e = 0; fl_e = 0; pc_e = 0; end
        chk("stall", 32'(stall), 32'(st_e));
        chk("flush", 32'(flush), 32'(fl_e));
        chk("new_pc", new_pc, pc_e);
        chk("stall_timeout", 32'(stall_timeout), 32'(r ? 1'b0 : m_to));
`ifdef PIPE_PERF_CNT_EN
        chk("stall_cycles", 32'(stall_cycles), r ? 0 : m_sc);
        chk("flush_count", 32'(flush_count), r ? 0 : m_fc);
`endif
        if (r) begin
            m_pending = 0; m_pend_pc = 0; m_run = 0; m_to = 0; m_sc = 0; m_fc = 0;
        end else begin
            if (m_em && e_rq && !m_pending) begin m_pending = 1; m_pend_pc = epc; end
            if (fl_e) m_pending = 0;
            if (st_e != 0) begin
                m_run++;
                if (m_run >= TO) m_to = 1;
                if (m_sc < CMAX) m_sc++;
            end else m_run = 0;
            if (fl_e && m_fc < CMAX) m_fc++;
        end
    endtask

    initial begin
        // Reset
        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(1, 1, 1, 1, 1, 1, 32'h44);
        // 1. Priority
        cycle(0, 0, 1, 1, 0, 0, 0);
        cycle(0, 0, 1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        // 2. Immediate flush overrides the id stall
        cycle(0, 0, 1, 0, 0, 1, 32'h20);
        cycle(0, 0, 0, 0, 0, 0, 0);
        // 3/4. Deferred flush, second exception ignored
        cycle(0, 0, 0, 0, 1, 1, 32'h180);
        cycle(0, 0, 0, 0, 1, 1, 32'h200);
        cycle(0, 1, 1, 0, 1, 0, 32'h0);
        cycle(0, 1, 1, 1, 0, 0, 32'h0);
        cycle(0, 0, 1, 0, 0, 0, 0);
        // 5. Watchdog on a held fetch stall; sticky afterwards
        cycle(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) cycle(0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        // Three stalled cycles stay below the limit
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        // 6. Reset while a flush is pending
        cycle(0, 0, 0, 0, 1, 1, 32'h300);
        cycle(0, 0, 0, 0, 1, 0, 0);
        cycle(1, 0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 299) == 0),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 7) == 0), $urandom & 32'hffff_fffc);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline sequencer for the 5-stage MIPS core.
- Merges stall requests from IF/ID/EX/MEM into the per-stage hold vector that gates every pipeline register (pc, if_id, id_ex, ex_mem, mem_wb, wb).
- Converts MEM-stage exception requests into a single-cycle pipeline flush with PC redirect. If an exception arrives during a MEM bus stall, the flush is deferred until the stall ends.
- Runs a stall watchdog.

Parameters:
- STALL_TIMEOUT, 1024: number of consecutive stalled cycles after which stall_timeout sets.
- CNT_W, 16: width of the watchdog counter and of the optional perf counters. Must satisfy 2^CNT_W > STALL_TIMEOUT.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- stallreq_if  in  1  fetch bus not ready
- stallreq_id  in  1  load-use hazard
- stallreq_ex  in  1  multi-cycle EX op (div/madd) busy
- stallreq_mem  in  1  data bus not ready
- excp_req  in  1  exception detected in MEM, level
- excp_pc  in  32  handler address accompanying excp_req
- stall  out  6  hold vector: [0] pc, [1] if_id, [2] id_ex, [3] ex_mem, [4] mem_wb, [5] wb
- flush  out  1  clear all pipeline registers this cycle
- new_pc  out  32  redirect target, valid when flush=1, else 0
- stall_timeout  out  1  sticky watchdog error
- stall_cycles  out  CNT_W  (PIPE_PERF_CNT_EN only) total stalled cycles
- flush_count  out  CNT_W  (PIPE_PERF_CNT_EN only) total flushes

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. While rst=1, all outputs are forced to 0 combinationally. On the clock edge with rst=1:
  - state <= RUN
  - pend_pc <= 0
  - wdog <= 0
  - stall_timeout <= 0
  - perf counters <= 0
- Stall encoding is combinational, same cycle. The highest-priority requester wins; the vectors are nested:
  - mem -> 6'b011111
  - ex -> 6'b001111
  - id -> 6'b000111
  - if -> 6'b000011
  - none -> 6'b000000
- States:
  - RUN: normal operation.
  - FLUSH_PEND: an exception is latched and waiting for the MEM stall to end.
- RUN, excp_req=1 and stallreq_mem=0:
  - flush=1, new_pc=excp_pc, stall=0 this cycle. Flush overrides all lower stall requests.
  - State stays RUN.
- RUN, excp_req=1 and stallreq_mem=1:
  - pend_pc <= excp_pc; next state FLUSH_PEND.
  - This cycle: stall=6'b011111, flush=0.
- FLUSH_PEND, stallreq_mem=1:
  - stall=6'b011111, flush=0.
  - Further excp_req is ignored; the first exception wins.
- FLUSH_PEND, stallreq_mem=0:
  - flush=1, new_pc=pend_pc, stall=0; next state RUN.
  - stallreq_if/id/ex are ignored in this cycle.
- flush is never high two consecutive cycles. After any flush, the next cycle is RUN with normal stall encoding.
- Watchdog counter wdog:
  - Increments each cycle stall!=0, saturating at 2^CNT_W-1.
  - Clears to 0 on any cycle with stall==0 or flush=1.
  - stall_timeout <= 1 when wdog==STALL_TIMEOUT-1 and stall!=0, i.e. on the STALL_TIMEOUT-th consecutive stalled cycle.
  - stall_timeout is sticky until rst.
- Reset mid-FLUSH_PEND discards the pending exception; no flush is issued afterwards.
- The block has no combinational path from stall outputs back to any request input.

Optional Feature:
- Macro PIPE_PERF_CNT_EN.
- When defined:
  - stall_cycles increments each cycle stall!=0.
  - flush_count increments each cycle flush=1.
  - Both are saturating and reset to 0.
- When undefined: both ports and their registers are absent. All other behaviour is identical.

Decomposition:
- Shared defines package holds:
  - stall bit indices: STALL_PC .. STALL_WB
  - the four stall vector constants
  - state encodings RUN/FLUSH_PEND
  - ZeroWord
- One natural sub-module: pipe_perf_cnt, a saturating counter pair instantiated only under PIPE_PERF_CNT_EN.

Test Plan:
1. Priority: stallreq_id=1 and stallreq_ex=1 together -> stall=6'b001111 that cycle. Drop ex -> 6'b000111. Drop all -> 6'b000000.
2. Immediate flush: excp_req=1, excp_pc=0x00000020, stallreq_id=1 -> same cycle flush=1, new_pc=0x20, stall=0. Next cycle flush=0, new_pc=0.
3. Deferred flush: stallreq_mem=1 for 3 cycles with excp_req=1, excp_pc=0x180 in cycle 1 -> stall=6'b011111 and flush=0 for 3 cycles. In the cycle stallreq_mem drops: flush=1, new_pc=0x180.
4. Second exception in FLUSH_PEND: excp_pc=0x200 during the pending hold -> flush redirects to the first address (0x180), not 0x200.
5. Watchdog: STALL_TIMEOUT=4, stallreq_if held high -> stall_timeout rises after the 4th stalled cycle and stays 1 after the request drops. Only rst clears it.
6. Reset in FLUSH_PEND: assert rst for 1 cycle with stallreq_mem still 1, then release it with stallreq_mem=0 -> flush stays 0. With PIPE_PERF_CNT_EN, stall_cycles and flush_count read 0.
